ifetch_pipe_112: RTL and testbench

Parametrised instruction-fetch stage, the pipelined successor of the single-cycle PC/next-PC block.
- Owns the PC and issues one word request per cycle to a synchronous instruction memory (1-cycle read latency).
- Buffers returned (pc, instr) pairs in a DEPTH-entry queue and presents them to decode through a valid/ready handshake.
- Branch, jump and JR targets are resolved downstream and arrive as a single redirect; redirect flushes everything younger.

---
 rtl/ifetch_pkg_112.sv | 18 +
 rtl/fifo_112.sv | 49 ++++
 rtl/ifetch_pipe_112.sv | 120 ++++++++++++
 tb/tb_ifetch_pipe_112.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg_112.sv
// rtl/ifetch_pkg_112.sv - shared opcodes, FSM states and queue entry type for the fetch stage
package ifetch_pkg_112;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam int         WORD_BYTES = 4;
  localparam int         ENTRY_PC_W = 32;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0] pc;
    logic [31:0]           instr;
  } entry_t;
endpackage

// File: rtl/fifo_112.sv
// rtl/fifo_112.sv - synchronous FIFO with flush; flush wins over a same-cycle push
module fifo_112 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || i_pop);
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
endmodule

// File: rtl/ifetch_pipe_112.sv
// rtl/ifetch_pipe_112.sv - pipelined instruction fetch with redirect and decode queue
// Optional J/JAL predecode redirect enabled by IFETCH_JUMP_PREDECODE_EN.
module ifetch_pipe_112
  import ifetch_pkg_112::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fault
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } fq_entry_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic              r_discard;
  logic              r_fault;
  logic              w_credit;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_jump;
  logic [ADDR_W-1:0] w_jump_target;
  logic [CW-1:0]     w_count;
  fq_entry_t         w_in;
  fq_entry_t         w_head;

  // Credit ignores a same-cycle pop so the issue decision never depends on decode.
  assign w_credit = (int'(w_count) + int'(r_inflight)) < DEPTH;
  assign w_issue  = !rst && (r_state == S_FETCH) && !redir_valid && w_credit;
  assign w_pop    = out_valid && out_ready;
  assign w_push   = r_inflight && !r_discard && (!w_full || w_pop);
  assign w_in.pc    = r_inflight_pc;
  assign w_in.instr = imem_rdata;

`ifdef IFETCH_JUMP_PREDECODE_EN
  logic [ADDR_W-1:0] w_pcp4;
  assign w_pcp4        = r_inflight_pc + ADDR_W'(WORD_BYTES);
  assign w_jump        = w_push && ((imem_rdata[31:26] == OP_J) || (imem_rdata[31:26] == OP_JAL));
  assign w_jump_target = ((w_pcp4 >> 28) << 28) | ADDR_W'({imem_rdata[25:0], 2'b00});
`else
  assign w_jump        = 1'b0;
  assign w_jump_target = '0;
`endif

  fifo_112 #(
    .WIDTH($bits(fq_entry_t)),
    .DEPTH(DEPTH)
  ) u_queue (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(redir_valid),
    .i_data (w_in),
    .o_data (w_head),
    .o_count(w_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: if (!w_credit) w_next = S_HOLD;
      S_HOLD:  if (w_credit) w_next = S_FETCH;
      default: w_next = S_RESET;
    endcase
    if (redir_valid && (r_state != S_RESET)) w_next = S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RESET;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_discard     <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      r_discard  <= redir_valid || w_jump;
      if (w_issue) r_inflight_pc <= r_pc;
      if (redir_valid)      r_pc <= {redir_target[ADDR_W-1:2], 2'b00};
      else if (w_jump)      r_pc <= w_jump_target;
      else if (w_issue)     r_pc <= r_pc + ADDR_W'(WORD_BYTES);
      if (redir_valid && (redir_target[1:0] != 2'b00)) r_fault <= 1'b1;
    end
  end

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;
  assign out_valid = !rst && !w_empty && !redir_valid;
  assign out_instr = (rst || w_empty) ? 32'd0 : w_head.instr;
  assign out_pc    = (rst || w_empty) ? '0 : w_head.pc;
  assign fault     = r_fault;
endmodule

// File: tb/tb_ifetch_pipe_112.sv
// tb/tb_ifetch_pipe_112.sv - self-checking bench for ifetch_pipe_112
module tb_ifetch_pipe_112;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_target = 32'd0;
  logic        out_ready = 1'b0;
  logic        jump_word_en = 1'b0;

  logic        imem_req, out_valid, fault;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
  logic        wrap_req, wrap_valid, wrap_fault;
  logic [31:0] wrap_addr, wrap_rdata, wrap_instr, wrap_pc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ifetch_pipe_112 #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redir_valid(redir_valid), .redir_target(redir_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .fault(fault)
  );

  ifetch_pipe_112 #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(wrap_req), .imem_addr(wrap_addr), .imem_rdata(wrap_rdata),
    .redir_valid(redir_valid), .redir_target(redir_target), .out_valid(wrap_valid),
    .out_ready(out_ready), .out_instr(wrap_instr), .out_pc(wrap_pc), .fault(wrap_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jump_word_en && (a == 32'h40)) return 32'h0800_0020;
    return {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) begin
    imem_rdata <= mem_word(imem_addr);
    wrap_rdata <= mem_word(wrap_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redir_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    total++; if (out_instr !== 32'd0) begin bad++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %0b want 0", fault); end
    total++; if (wrap_req !== 1'b0) begin bad++; $display("FAIL reset_wrap_req: got %0b want 0", wrap_req); end
  endtask

  task automatic test_sequential();
    int first_req = -1;
    int first_val = -1;
    int n_out = 0;
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_out = 32'd0;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      tick(); rst = 1'b0; out_ready = 1'b1; settle();
      if (imem_req && first_req < 0) first_req = k;
      if (first_req >= 0) begin
        total++;
        if (imem_req !== 1'b1) begin bad++; $display("FAIL seq_req_gap: cycle %0d got req %0b want 1", k, imem_req); end
        else if (imem_addr !== exp_addr) begin bad++; $display("FAIL seq_addr: got %h want %h", imem_addr, exp_addr); end
        exp_addr += 32'd4;
      end
      if (out_valid && first_val < 0) begin
        first_val = k;
        total++;
        if (first_val != first_req + 2) begin bad++; $display("FAIL seq_first_valid: got cycle %0d want %0d", first_val, first_req + 2); end
      end
      if (first_val >= 0) begin
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL seq_throughput: cycle %0d got valid %0b want 1", k, out_valid); end
        else if (out_pc !== exp_out || out_instr !== {2'b00, exp_out[31:2]}) begin
          bad++; $display("FAIL seq_data: got pc %h instr %h want pc %h instr %h", out_pc, out_instr, exp_out, {2'b00, exp_out[31:2]});
        end
        exp_out += 32'd4;
        n_out++;
      end
    end
    total++; if (n_out < 20) begin bad++; $display("FAIL seq_count: got %0d want >=20", n_out); end
  endtask

  task automatic test_backpressure();
    int n_req = 0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick(); rst = 1'b0; out_ready = 1'b0; settle();
      if (imem_req) n_req++;
      if (out_valid) begin
        total++;
        if (out_pc !== 32'd0 || out_instr !== 32'd0) begin bad++; $display("FAIL bp_head_stable: got pc %h instr %h want 0 0", out_pc, out_instr); end
      end
    end
    total++; if (n_req != 4) begin bad++; $display("FAIL bp_req_count: got %0d want 4", n_req); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_stop: got %0b want 0", imem_req); end
    for (int k = 0; k < 4; k++) begin
      tick(); out_ready = 1'b1; settle();
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'(k)) begin
        bad++; $display("FAIL bp_drain: got valid %0b pc %h instr %h want 1 %h %h", out_valid, out_pc, out_instr, 32'(4 * k), 32'(k));
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc = 32'h104;
    do_reset();
    for (int k = 0; k < 10; k++) begin tick(); rst = 1'b0; out_ready = 1'b0; end
    tick(); redir_valid = 1'b1; redir_target = 32'h100; settle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_r_valid: got %0b want 0", out_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_r_req: got %0b want 0", imem_req); end
    tick(); redir_valid = 1'b0; out_ready = 1'b1; settle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_r1_valid: got %0b want 0", out_valid); end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL redir_r1_req: got req %0b addr %h want 1 100", imem_req, imem_addr); end
    tick(); settle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_r2_valid: got %0b want 0", out_valid); end
    tick(); settle();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h40) begin
      bad++; $display("FAIL redir_r3_head: got valid %0b pc %h instr %h want 1 100 40", out_valid, out_pc, out_instr);
    end
    for (int k = 0; k < 6; k++) begin
      tick(); settle();
      if (out_valid) begin
        total++;
        if (out_pc !== exp_pc) begin bad++; $display("FAIL redir_stale: got pc %h want %h", out_pc, exp_pc); end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_fault();
    do_reset();
    for (int k = 0; k < 3; k++) begin tick(); rst = 1'b0; out_ready = 1'b1; end
    tick(); redir_valid = 1'b1; redir_target = 32'h102; settle();
    tick(); redir_valid = 1'b0; settle();
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_set: got %0b want 1", fault); end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL fault_resume: got req %0b addr %h want 1 100", imem_req, imem_addr); end
    tick(); tick(); settle();
    total++; if (out_pc !== 32'h100) begin bad++; $display("FAIL fault_head: got %h want 100", out_pc); end
    tick(); redir_valid = 1'b1; redir_target = 32'h200; settle();
    for (int k = 0; k < 4; k++) begin
      tick(); redir_valid = 1'b0; settle();
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_sticky: got %0b want 1", fault); end
    end
    tick(); rst = 1'b1; tick(); settle();
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_clear: got %0b want 0", fault); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr = 32'hFFFF_FFF8;
    logic [31:0] exp_out = 32'hFFFF_FFF8;
    int n_req = 0;
    int n_out = 0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tick(); rst = 1'b0; out_ready = 1'b1; settle();
      if (wrap_req && n_req < 4) begin
        total++;
        if (wrap_addr !== exp_addr) begin bad++; $display("FAIL wrap_addr: got %h want %h", wrap_addr, exp_addr); end
        exp_addr += 32'd4; n_req++;
      end
      if (wrap_valid && n_out < 3) begin
        total++;
        if (wrap_pc !== exp_out || wrap_instr !== {2'b00, exp_out[31:2]}) begin
          bad++; $display("FAIL wrap_out: got pc %h instr %h want %h %h", wrap_pc, wrap_instr, exp_out, {2'b00, exp_out[31:2]});
        end
        exp_out += 32'd4; n_out++;
      end
    end
    total++; if (n_req != 4 || n_out != 3) begin bad++; $display("FAIL wrap_count: got req %0d out %0d want 4 3", n_req, n_out); end
  endtask

  task automatic test_jump();
    logic [31:0] exp_seq [3];
    int n = 0;
`ifdef IFETCH_JUMP_PREDECODE_EN
    exp_seq = '{32'h40, 32'h80, 32'h84};
`else
    exp_seq = '{32'h40, 32'h44, 32'h48};
`endif
    jump_word_en = 1'b1;
    do_reset();
    tick(); rst = 1'b0; out_ready = 1'b1; redir_valid = 1'b1; redir_target = 32'h40; settle();
    for (int k = 0; k < 20; k++) begin
      tick(); redir_valid = 1'b0; settle();
      if (out_valid && n < 3) begin
        total++;
        if (out_pc !== exp_seq[n]) begin bad++; $display("FAIL jump_seq%0d: got pc %h want %h", n, out_pc, exp_seq[n]); end
        if (n == 0) begin
          total++;
          if (out_instr !== 32'h0800_0020) begin bad++; $display("FAIL jump_word: got %h want 08000020", out_instr); end
        end
        n++;
      end
    end
    total++; if (n != 3) begin bad++; $display("FAIL jump_count: got %0d want 3", n); end
    jump_word_en = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = 32'd0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_pc = 32'd0;
    logic [31:0] prev_instr = 32'd0;
    int n_xfer = 0;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      tick();
      rst = 1'b0;
      redir_valid = ($urandom_range(0, 99) < 4);
      redir_target = 32'($urandom_range(0, 32'h3FFF)) << 2;
      out_ready = ($urandom_range(0, 99) < 65);
      settle();
      if (redir_valid) begin
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_redir_valid: got %0b want 0", out_valid); end
        exp_pc = redir_target;
      end else begin
        if (prev_valid && !prev_ready) begin
          total++;
          if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instr !== prev_instr) begin
            bad++; $display("FAIL rnd_hold: got valid %0b pc %h instr %h want 1 %h %h", out_valid, out_pc, out_instr, prev_pc, prev_instr);
          end
        end
        if (out_valid && out_ready) begin
          total++;
          if (out_pc !== exp_pc || out_instr !== {2'b00, exp_pc[31:2]}) begin
            bad++; $display("FAIL rnd_xfer: got pc %h instr %h want %h %h", out_pc, out_instr, exp_pc, {2'b00, exp_pc[31:2]});
          end
          exp_pc += 32'd4;
          n_xfer++;
        end
      end
      prev_valid = out_valid; prev_ready = out_ready; prev_pc = out_pc; prev_instr = out_instr;
    end
    redir_valid = 1'b0;
    total++; if (n_xfer < 100) begin bad++; $display("FAIL rnd_progress: got %0d want >=100", n_xfer); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL rnd_fault: got %0b want 0", fault); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_fault();
    test_wrap();
    test_jump();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
